// File: rtl/jogo_playseq_pkg.sv
// jogo_playseq_pkg: state codes, durations and ROM sequence banks for the memory game
package jogo_playseq_pkg;
  typedef enum logic [3:0] {
    INICIAL        = 4'h0,
    PREPARA        = 4'h1,
    GRAVA_ESPERA   = 4'h2,
    GRAVA          = 4'h3,
    MOSTRA_LIGA    = 4'h4,
    MOSTRA_DESLIGA = 4'h5,
    ESPERA         = 4'h6,
    COMPARA        = 4'h7,
    PROXIMA_RODADA = 4'h8,
    GANHOU         = 4'hC,
    PERDEU         = 4'hD,
    ESGOTOU        = 4'hE
  } state_t;
  localparam int HALF_MS = 500;
  localparam int TO0_MS  = 2000;
  localparam int TO1_MS  = 3000;
  localparam int TO2_MS  = 5000;
  localparam int TO3_MS  = 10000;
  // Banks 0..2, address 0 in the least significant nibble
  localparam logic [2:0][63:0] ROM = {
    64'h4281_1824_2148_8412,
    64'h8421_1122_4488_2211,
    64'h1248_8421_2481_4218
  };
  function automatic int ms_to_cycles(input int hz, input int ms);
    return hz * ms / 1000;
  endfunction
  function automatic logic [3:0] rom_word(input logic [1:0] bank, input logic [3:0] addr);
    return ROM[bank][{addr, 2'b00} +: 4];
  endfunction
endpackage

// File: rtl/jogo_playseq_hexa7seg.sv
// hexa7seg: hex digit to active-high gfedcba segment pattern
module hexa7seg (
  input  logic [3:0] hexa_i,
  output logic [6:0] seg_o
);
  localparam logic [15:0][6:0] SEG = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };
  assign seg_o = SEG[hexa_i];
endmodule

// File: rtl/jogo_playseq.sv
// jogo_playseq: Genius-style memory game with four sequence banks, recordable bank 3,
// round replay, timed player entry and board debug outputs.
module jogo_playseq
  import jogo_playseq_pkg::*;
#(
  parameter int CLK_HZ = 1000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       jogar,
  input  logic [3:0] botoes,
  input  logic [1:0] nivel,
  input  logic [1:0] memoria,
  input  logic [1:0] timeoutD,
  input  logic       quer_escrever,
  output logic       ganhou,
  output logic       perdeu,
  output logic       timeout,
  output logic       pronto,
  output logic [3:0] leds,
  output logic       db_clock,
  output logic       db_tem_jogada,
  output logic       db_chavesIgualMemoria,
  output logic       db_enderecoIgualSequencia,
  output logic       db_fimS,
  output logic [6:0] db_contagem,
  output logic [6:0] db_memoria,
  output logic [6:0] db_jogadafeita,
  output logic [6:0] db_sequencia,
  output logic [6:0] db_estado,
  output logic       db_seletor_memoria,
  output logic       db_pare,
  output logic [1:0] db_contagem_jogo,
  output logic [6:0] vitorias,
  output logic [6:0] derrotas
);
  localparam logic [31:0] HALF_LIM = 32'(ms_to_cycles(CLK_HZ, HALF_MS) - 1);
  localparam logic [31:0] TO0_LIM  = 32'(ms_to_cycles(CLK_HZ, TO0_MS) - 1);
  localparam logic [31:0] TO1_LIM  = 32'(ms_to_cycles(CLK_HZ, TO1_MS) - 1);
  localparam logic [31:0] TO2_LIM  = 32'(ms_to_cycles(CLK_HZ, TO2_MS) - 1);
  localparam logic [31:0] TO3_LIM  = 32'(ms_to_cycles(CLK_HZ, TO3_MS) - 1);
  state_t      state_q, state_d;
  logic [3:0]  addr_q, addr_d;
  logic [4:0]  s_q, s_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] timer_q, timer_d;
  logic [1:0]  nivel_q, mem_sel_q;
  logic [3:0]  prev_q, jogada_q, vit_q, der_q;
  logic [3:0]  ram_q [16];
  logic [3:0]  mem_data, seq_disp;
  logic [4:0]  s_sum, s_sat;
  logic [31:0] to_lim;
  logic        tem_jogada, start, wr_en, win_ev, loss_ev, echo, addr_eq_seq;
  assign tem_jogada  = (botoes != 4'd0) && (prev_q == 4'd0);
  assign mem_data    = (mem_sel_q == 2'd3) ? ram_q[addr_q] : rom_word(mem_sel_q, addr_q);
  assign addr_eq_seq = {1'b0, addr_q} == (s_q - 5'd1);
  assign s_sum       = s_q + {3'b000, nivel_q} + 5'd1;
  assign s_sat       = (s_sum > 5'd16) ? 5'd16 : s_sum;
  assign to_lim      = (timeoutD == 2'd0) ? TO0_LIM : (timeoutD == 2'd1) ? TO1_LIM :
                       (timeoutD == 2'd2) ? TO2_LIM : TO3_LIM;
  assign win_ev      = (state_d == GANHOU) && (state_q != GANHOU);
  assign loss_ev     = (state_d == PERDEU || state_d == ESGOTOU) && (state_d != state_q);
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
    timer_d = timer_q;
    start   = 1'b0;
    wr_en   = 1'b0;
    case (state_q)
      INICIAL, GANHOU, PERDEU, ESGOTOU: begin
        start   = jogar;
        state_d = jogar ? PREPARA : state_q;
      end
      PREPARA: begin
        addr_d  = 4'd0;
        s_d     = 5'd0;
        cnt_d   = 2'd0;
        timer_d = 32'd0;
        state_d = quer_escrever ? GRAVA_ESPERA : ESPERA;
      end
      GRAVA_ESPERA: state_d = tem_jogada ? GRAVA : GRAVA_ESPERA;
      GRAVA: begin
        wr_en   = 1'b1;
        addr_d  = addr_q + 4'd1;
        state_d = (addr_q == 4'hF) ? ESPERA : GRAVA_ESPERA;
      end
      MOSTRA_LIGA: begin
        timer_d = (timer_q == HALF_LIM) ? 32'd0 : timer_q + 32'd1;
        state_d = (timer_q == HALF_LIM) ? MOSTRA_DESLIGA : MOSTRA_LIGA;
      end
      MOSTRA_DESLIGA: begin
        timer_d = (timer_q == HALF_LIM) ? 32'd0 : timer_q + 32'd1;
        if (timer_q == HALF_LIM) begin
          addr_d  = addr_eq_seq ? addr_q : addr_q + 4'd1;
          state_d = addr_eq_seq ? ESPERA : MOSTRA_LIGA;
        end
      end
      ESPERA: begin
        // A play in the expiry cycle takes priority over the timeout
        addr_d  = s_q[3:0] + {2'b00, cnt_q};
        timer_d = (tem_jogada || timer_q == to_lim) ? 32'd0 : timer_q + 32'd1;
        state_d = tem_jogada ? COMPARA : (timer_q == to_lim) ? ESGOTOU : ESPERA;
      end
      COMPARA: begin
        timer_d = 32'd0;
        cnt_d   = cnt_q + 2'd1;
        state_d = (jogada_q != mem_data) ? PERDEU :
                  (cnt_q == nivel_q || addr_q == 4'hF) ? PROXIMA_RODADA : ESPERA;
      end
      PROXIMA_RODADA: begin
        s_d     = s_sat;
        cnt_d   = 2'd0;
        addr_d  = 4'd0;
        timer_d = 32'd0;
        state_d = (s_sat == 5'd16) ? GANHOU : MOSTRA_LIGA;
      end
      default: state_d = INICIAL;
    endcase
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= INICIAL;
      addr_q    <= '0;
      s_q       <= '0;
      cnt_q     <= '0;
      timer_q   <= '0;
      nivel_q   <= '0;
      mem_sel_q <= '0;
      prev_q    <= '0;
      jogada_q  <= '0;
      vit_q     <= '0;
      der_q     <= '0;
      for (int i = 0; i < 16; i++) ram_q[i] <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      timer_q <= timer_d;
      prev_q  <= botoes;
      if (tem_jogada) jogada_q <= botoes;
      if (start) begin
        nivel_q   <= nivel;
        mem_sel_q <= memoria;
      end
      if (wr_en) ram_q[addr_q] <= jogada_q;
      if (win_ev && vit_q != 4'hF) vit_q <= vit_q + 4'd1;
      if (loss_ev && der_q != 4'hF) der_q <= der_q + 4'd1;
    end
  end
  assign echo     = (state_q == GRAVA_ESPERA) || (state_q == GRAVA) ||
                    (state_q == ESPERA) || (state_q == COMPARA);
  assign leds     = (state_q == MOSTRA_LIGA) ? mem_data : echo ? botoes : 4'd0;
  assign ganhou   = state_q == GANHOU;
  assign perdeu   = state_q == PERDEU;
  assign timeout  = state_q == ESGOTOU;
  assign pronto   = ganhou || perdeu || timeout;
  assign seq_disp = (s_q == 5'd0) ? 4'd0 : 4'(s_q - 5'd1);
  assign db_clock                  = clock;
  assign db_tem_jogada             = tem_jogada;
  assign db_chavesIgualMemoria     = botoes == mem_data;
  assign db_enderecoIgualSequencia = addr_eq_seq;
  assign db_fimS                   = s_q == 5'd16;
  assign db_seletor_memoria        = mem_sel_q == 2'd3;
  assign db_pare                   = state_q == PROXIMA_RODADA;
  assign db_contagem_jogo          = cnt_q;
  hexa7seg u_hex_addr (.hexa_i(addr_q),   .seg_o(db_contagem));
  hexa7seg u_hex_mem  (.hexa_i(mem_data), .seg_o(db_memoria));
  hexa7seg u_hex_jog  (.hexa_i(jogada_q), .seg_o(db_jogadafeita));
  hexa7seg u_hex_seq  (.hexa_i(seq_disp), .seg_o(db_sequencia));
  hexa7seg u_hex_est  (.hexa_i(state_q),  .seg_o(db_estado));
  hexa7seg u_hex_vit  (.hexa_i(vit_q),    .seg_o(vitorias));
  hexa7seg u_hex_der  (.hexa_i(der_q),    .seg_o(derrotas));
endmodule

// File: tb/tb_jogo_playseq.sv
// tb_jogo_playseq: directed game scenarios (record, win twice, lose, timeout, reset)
// run at a reduced clock rate so durations stay short.
module tb_jogo_playseq;
  localparam int HZ   = 100;
  localparam int HALF = 50;
  localparam int TO0  = 200;
  logic clock = 1'b0, reset = 1'b0, jogar = 1'b0, quer_escrever = 1'b0;
  logic [3:0] botoes = 4'd0;
  logic [1:0] nivel = 2'd0, memoria = 2'd0, timeoutD = 2'd0;
  logic ganhou, perdeu, timeout, pronto, db_clock, db_tem_jogada;
  logic db_chavesIgualMemoria, db_enderecoIgualSequencia, db_fimS;
  logic db_seletor_memoria, db_pare;
  logic [3:0] leds;
  logic [1:0] db_contagem_jogo;
  logic [6:0] db_contagem, db_memoria, db_jogadafeita, db_sequencia, db_estado;
  logic [6:0] vitorias, derrotas;
  int passed = 0, total = 0;
  always #5 clock = ~clock;
  jogo_playseq #(.CLK_HZ(HZ)) dut (
    .clock(clock), .reset(reset), .jogar(jogar), .botoes(botoes), .nivel(nivel),
    .memoria(memoria), .timeoutD(timeoutD), .quer_escrever(quer_escrever),
    .ganhou(ganhou), .perdeu(perdeu), .timeout(timeout), .pronto(pronto), .leds(leds),
    .db_clock(db_clock), .db_tem_jogada(db_tem_jogada),
    .db_chavesIgualMemoria(db_chavesIgualMemoria),
    .db_enderecoIgualSequencia(db_enderecoIgualSequencia), .db_fimS(db_fimS),
    .db_contagem(db_contagem), .db_memoria(db_memoria), .db_jogadafeita(db_jogadafeita),
    .db_sequencia(db_sequencia), .db_estado(db_estado),
    .db_seletor_memoria(db_seletor_memoria), .db_pare(db_pare),
    .db_contagem_jogo(db_contagem_jogo), .vitorias(vitorias), .derrotas(derrotas)
  );
  function automatic logic [6:0] seg7(input logic [3:0] h);
    case (h)
      4'h0: return 7'h3F; 4'h1: return 7'h06; 4'h2: return 7'h5B; 4'h3: return 7'h4F;
      4'h4: return 7'h66; 4'h5: return 7'h6D; 4'h6: return 7'h7D; 4'h7: return 7'h07;
      4'h8: return 7'h7F; 4'h9: return 7'h6F; 4'hA: return 7'h77; 4'hB: return 7'h7C;
      4'hC: return 7'h39; 4'hD: return 7'h5E; 4'hE: return 7'h79; default: return 7'h71;
    endcase
  endfunction
  function automatic logic [3:0] pat(input int i);
    return 4'b0001 << (i % 4);
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask
  task automatic wait_state(input logic [3:0] code, input int budget);
    int n = 0;
    while (db_estado !== seg7(code) && n < budget) begin
      @(negedge clock);
      n++;
    end
    if (n >= budget) check($sformatf("reach_state_%0h", code), 32'(db_estado), 32'(seg7(code)));
  endtask
  task automatic press(input logic [3:0] b);
    botoes = b;
    @(negedge clock);
    botoes = 4'd0;
    @(negedge clock);
  endtask
  task automatic start_game;
    jogar = 1'b1;
    @(negedge clock);
    jogar = 1'b0;
  endtask
  task automatic play_game(input bit timed);
    int s = 0;
    int n;
    while (s < 16) begin
      for (int i = 0; i < s; i++) begin
        wait_state(4'h4, 400);
        check("show_led", 32'(leds), 32'(pat(i)));
        if (timed && s == 3 && i == 0) begin
          n = 0;
          while (db_estado === seg7(4'h4) && n < 1000) begin n++; @(negedge clock); end
          check("on_cycles", 32'(n), 32'(HALF));
          n = 0;
          while (db_estado === seg7(4'h5) && n < 1000) begin n++; @(negedge clock); end
          check("off_cycles", 32'(n), 32'(HALF));
        end else begin
          wait_state(4'h5, 400);
          check("dark_led", 32'(leds), 32'd0);
        end
      end
      for (int k = 0; k < 3 && s + k < 16; k++) begin
        wait_state(4'h6, 400);
        press(pat(s + k));
      end
      check("round_pare", 32'(db_pare), 32'd1);
      s = (s + 3 > 16) ? 16 : s + 3;
    end
    @(negedge clock);
    check("win_state", 32'(db_estado), 32'(seg7(4'hC)));
    check("win_flag", 32'(ganhou), 32'd1);
    check("win_pronto", 32'(pronto), 32'd1);
    check("win_fimS", 32'(db_fimS), 32'd1);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end
  initial begin
    int n;
    @(negedge clock);
    reset = 1'b1;
    check("rst_state", 32'(db_estado), 32'(seg7(4'h0)));
    check("rst_flags", {28'd0, ganhou, perdeu, timeout, pronto}, 32'd0);
    check("rst_leds", 32'(leds), 32'd0);
    check("rst_vit", 32'(vitorias), 32'(seg7(4'h0)));
    check("rst_der", 32'(derrotas), 32'(seg7(4'h0)));
    check("rst_seq", 32'(db_sequencia), 32'(seg7(4'h0)));
    quer_escrever = 1'b1;
    memoria = 2'd3;
    nivel = 2'd2;
    timeoutD = 2'd3;
    start_game();
    for (int i = 0; i < 16; i++) begin
      wait_state(4'h2, 20);
      press(pat(i));
    end
    check("rec_done_state", 32'(db_estado), 32'(seg7(4'h6)));
    check("rec_addr", 32'(db_contagem), 32'(seg7(4'h0)));
    check("bank3_sel", 32'(db_seletor_memoria), 32'd1);
    play_game(1'b1);
    check("vit_1", 32'(vitorias), 32'(seg7(4'h1)));
    quer_escrever = 1'b0;
    start_game();
    wait_state(4'h6, 10);
    play_game(1'b0);
    check("vit_2", 32'(vitorias), 32'(seg7(4'h2)));
    start_game();
    for (int k = 0; k < 3; k++) begin
      wait_state(4'h6, 20);
      press(pat(k));
    end
    wait_state(4'h6, 1000);
    press(4'b0001);
    check("lose_state", 32'(db_estado), 32'(seg7(4'hD)));
    check("lose_flags", {28'd0, ganhou, perdeu, timeout, pronto}, 32'b0101);
    check("der_1", 32'(derrotas), 32'(seg7(4'h1)));
    check("vit_kept", 32'(vitorias), 32'(seg7(4'h2)));
    timeoutD = 2'd0;
    start_game();
    wait_state(4'h6, 10);
    n = 0;
    while (db_estado === seg7(4'h6) && n < 5000) begin n++; @(negedge clock); end
    check("to_cycles", 32'(n), 32'(TO0));
    check("to_state", 32'(db_estado), 32'(seg7(4'hE)));
    check("to_flags", {28'd0, ganhou, perdeu, timeout, pronto}, 32'b0011);
    check("der_2", 32'(derrotas), 32'(seg7(4'h2)));
    start_game();
    wait_state(4'h6, 10);
    repeat (TO0 - 1) @(negedge clock);
    botoes = pat(0);
    @(negedge clock);
    check("late_press", 32'(db_estado), 32'(seg7(4'h7)));
    botoes = 4'd0;
    @(negedge clock);
    check("late_back", 32'(db_estado), 32'(seg7(4'h6)));
    check("late_count", 32'(db_contagem_jogo), 32'd1);
    #3 reset = 1'b0;
    #1;
    check("arst_state", 32'(db_estado), 32'(seg7(4'h0)));
    check("arst_cnt", {18'd0, vitorias, derrotas}, {18'd0, seg7(4'h0), seg7(4'h0)});
    check("arst_leds", 32'(leds), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    timeoutD = 2'd3;
    start_game();
    wait_state(4'h6, 10);
    check("cleared_sel", 32'(db_seletor_memoria), 32'd1);
    check("cleared_mem", 32'(db_memoria), 32'(seg7(4'h0)));
    press(4'b0001);
    check("cleared_lose", 32'(db_estado), 32'(seg7(4'hD)));
    check("cleared_der", 32'(derrotas), 32'(seg7(4'h1)));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
